// File: rtl/wind_pkg.sv
// Shared types and defaults for the burst transmitter.
// Holds the FSM encoding and the counter width defaults.
package wind_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    GUARD  = 2'd2,
    LISTEN = 2'd3
  } state_t;

  localparam int CW_DEF = 16;
  localparam int SW_DEF = 12;

endpackage

// File: rtl/burst_tx_tick_counter.sv
// Loadable down-counter with terminal-count flag.
// Holds at zero; load wins over decrement.
module tick_counter
  import wind_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] value,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/burst_tx.sv
// Ultrasonic burst transmitter: excite, ring down, listen.
// Config is captured on an accepted start and held for the cycle.
module burst_tx
  import wind_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] halfper,
  input  logic [5:0]    ncycles,
  input  logic [CW-1:0] guard,
  input  logic [CW-1:0] sampdiv,
  input  logic [SW-1:0] nsamples,
  output logic          txp,
  output logic          txn,
  output logic          enable,
  output logic          sample,
  output logic          busy,
  output logic          done
);

  state_t state, nxt;

  logic [CW-1:0] hp_q, gd_q, sd_q;
  logic [SW-1:0] ns_q;
  logic [6:0]    halves;
  logic          phase, done_q;

  logic          idle, accept;
  logic [CW-1:0] hp_s, gd_s, sd_s;
  logic [SW-1:0] ns_s;
  logic [CW-1:0] hp_rl, gd_rl, sd_rl, ns_rl;
  logic [CW-1:0] iv_val;
  logic          hp_tc, iv_tc, sd_tc, smp;
  logic          in_burst, in_guard, in_listen;
  logic          go_burst, go_guard, go_listen, fin;

  assign idle      = (state == IDLE);
  assign in_burst  = (state == BURST);
  assign in_guard  = (state == GUARD);
  assign in_listen = (state == LISTEN);
  assign accept    = idle & start & ~abort;

  // Live inputs only matter on the accepting clock.
  assign hp_s = idle ? halfper  : hp_q;
  assign gd_s = idle ? guard    : gd_q;
  assign sd_s = idle ? sampdiv  : sd_q;
  assign ns_s = idle ? nsamples : ns_q;

  assign hp_rl = (hp_s == '0) ? '0 : hp_s - CW'(1);
  assign gd_rl = (gd_s == '0) ? '0 : gd_s - CW'(1);
  assign sd_rl = (sd_s == '0) ? '0 : sd_s - CW'(1);
  assign ns_rl = (ns_s == '0) ? '0 : CW'(ns_s) - CW'(1);

  assign smp = in_listen & sd_tc;

  always_comb begin
    nxt       = state;
    go_burst  = 1'b0;
    go_guard  = 1'b0;
    go_listen = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (ncycles != '0)   go_burst  = 1'b1;
          else if (gd_s != '0) go_guard  = 1'b1;
          else if (ns_s != '0) go_listen = 1'b1;
          else                 fin       = 1'b1;
        end
      end
      BURST: begin
        if (!abort && hp_tc && halves == 7'd1) begin
          if (gd_s != '0)      go_guard  = 1'b1;
          else if (ns_s != '0) go_listen = 1'b1;
          else                 fin       = 1'b1;
        end
      end
      GUARD: begin
        if (!abort && iv_tc) begin
          if (ns_s != '0) go_listen = 1'b1;
          else            fin       = 1'b1;
        end
      end
      LISTEN: begin
        if (!abort && smp && iv_tc) fin = 1'b1;
      end
    endcase
    unique case (1'b1)
      go_burst:    nxt = BURST;
      go_guard:    nxt = GUARD;
      go_listen:   nxt = LISTEN;
      fin | abort: nxt = IDLE;
      default:     ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
      hp_q   <= '0;
      gd_q   <= '0;
      sd_q   <= '0;
      ns_q   <= '0;
      halves <= '0;
      phase  <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= fin;
      if (accept) begin
        hp_q <= halfper;
        gd_q <= guard;
        sd_q <= sampdiv;
        ns_q <= nsamples;
      end
      if (go_burst) begin
        halves <= {ncycles, 1'b0};
        phase  <= 1'b0;
      end else if (in_burst && hp_tc) begin
        if (halves != '0) halves <= halves - 7'd1;
        phase <= ~phase;
      end
    end
  end

  assign iv_val = go_guard ? gd_rl : ns_rl;

  tick_counter #(.CW(CW)) u_hp (
    .clock (clock),
    .reset (reset),
    .load  (go_burst | (in_burst & hp_tc)),
    .en    (in_burst),
    .value (hp_rl),
    .tc    (hp_tc)
  );

  // Counts guard clocks, then remaining strobes in LISTEN.
  tick_counter #(.CW(CW)) u_iv (
    .clock (clock),
    .reset (reset),
    .load  (go_guard | go_listen),
    .en    (in_guard | smp),
    .value (iv_val),
    .tc    (iv_tc)
  );

  tick_counter #(.CW(CW)) u_sd (
    .clock (clock),
    .reset (reset),
    .load  (go_listen | smp),
    .en    (in_listen),
    .value (sd_rl),
    .tc    (sd_tc)
  );

  assign txp    = in_burst & ~phase;
  assign txn    = in_burst & phase;
  assign enable = in_listen;
  assign sample = smp;
  assign busy   = ~idle;
  assign done   = done_q;

endmodule

// File: doc/burst_tx.md
BURST_TX -- requirements
Module: burst_tx

Interface
REQ-001 Parameter: CW, default 16, width of the period/guard/divider counters.
REQ-002 Parameter: SW, default 12, width of the sample-count input.
REQ-003 clock  input  1  master clock, single clock domain; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  master reset, synchronous, active-low.
REQ-005 start  input  1  one-clock request to begin a measurement cycle.
REQ-006 abort  input  1  terminates any cycle in progress.
REQ-007 halfper  input  CW  clocks per half period of the transducer excitation (1250 gives 40 kHz at 100 MHz).
REQ-008 ncycles  input  6  number of excitation periods in the burst.
REQ-009 guard  input  CW  ring-down clocks between the end of the burst and the listen window.
REQ-010 sampdiv  input  CW  clocks between sample strobes during listen.
REQ-011 nsamples  input  SW  number of sample strobes per listen window.
REQ-012 txp, txn  output  1 each  complementary transducer drive.
REQ-013 enable  output  1  receive-chain enable.
REQ-014 sample  output  1  one-clock sample strobe to the receive chain.
REQ-015 busy  output  1  cycle in progress.
REQ-016 done  output  1  one-clock end-of-cycle pulse.

Function
REQ-017 FSM states SHALL be IDLE, BURST, GUARD and LISTEN.
REQ-018 In IDLE, start=1 SHALL latch all configuration inputs; configuration changes after the latch SHALL have no effect until the next start.
REQ-019 The clock after start is sampled, the block SHALL enter BURST with busy=1, txp=1, txn=0.
REQ-020 In BURST, txp and txn SHALL invert every halfper clocks; txp and txn SHALL never be high in the same cycle.
REQ-021 BURST SHALL last exactly 2*ncycles*halfper clocks, after which txp=txn=0.
REQ-022 GUARD SHALL last exactly guard clocks, with all drive, enable and sample outputs low.
REQ-023 In LISTEN, enable SHALL be 1 from the first LISTEN clock up to and including the clock of the last strobe.
REQ-024 In LISTEN, sample SHALL pulse on the sampdiv-th LISTEN clock and every sampdiv clocks thereafter, nsamples times in total.
REQ-025 The clock after the last strobe, the block SHALL be in IDLE with done=1, busy=0, enable=0.
REQ-026 Zero-value rules:
  - halfper=0 and sampdiv=0 SHALL each be treated as 1.
  - ncycles=0 SHALL skip BURST.
  - guard=0 SHALL skip GUARD.
  - nsamples=0 SHALL skip LISTEN; done then asserts on the clock the skipped state would have begun.
REQ-027 start while busy=1 SHALL be ignored; start in the same clock that done pulses SHALL be accepted.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next clock with all outputs 0 and no done pulse; abort has priority over start.
REQ-029 Counters SHALL be CW bits wide with no wrap-around: terminal-count detection before reload, and no counter underflow.

Reset
REQ-030 While reset=0 at a clock edge, the block SHALL enter IDLE with txp=txn=enable=sample=busy=done=0, and SHALL clear all counters and latched configuration.
REQ-031 Reset asserted mid-cycle SHALL take effect at the next clock edge, with no done pulse.

Structure
REQ-032 State encoding and the CW/SW defaults SHALL reside in the shared package wind_pkg.
REQ-033 One sub-module, tick_counter, SHALL be used: a loadable CW-bit down-counter with terminal-count output, instantiated for the half-period, guard/listen interval, and sample-divider timing.

Verification
REQ-034 Basic cycle: halfper=4, ncycles=2, guard=3, sampdiv=5, nsamples=3, start pulse. Required response:
  - txp high clocks 1-4 and 9-12, txn high clocks 5-8 and 13-16 (clock 1 = cycle after start).
  - Drive low clocks 17-19.
  - enable high clocks 20-34, sample at clocks 24, 29, 34.
  - done at clock 35.
REQ-035 Zero skips: ncycles=0, guard=0, sampdiv=1, nsamples=2 -> enable high at clock 1, sample at clocks 1 and 2, done at clock 3, txp/txn never high.
REQ-036 Abort: abort=1 at the 6th BURST clock of REQ-034 stimulus -> next clock all outputs 0, no done; a fresh start 2 clocks later runs the full REQ-034 sequence.
REQ-037 Reset mid-cycle: reset=0 for 1 clock during LISTEN -> next clock all outputs 0, FSM in IDLE, no done.
REQ-038 Start while busy plus configuration change mid-cycle: start repeated during BURST and halfper changed to 9 -> timing unchanged from REQ-034; start coincident with done -> new cycle begins, with txp high the following clock.
